// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, parametrised ALU with registered result port.
// Single-cycle ops complete in one cycle; opcode 8 is an optional
// shift-add multiply built only when the ALU_MUL_EN macro is defined.
// Without ALU_MUL_EN, opcode 8 is reported as illegal and no BUSY
// state or step counter exists.
module alu_pipe #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             zero,
  output logic             illegal
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SHL  = 4'd5;
  localparam logic [3:0] OP_SHR  = 4'd6;
  localparam logic [3:0] OP_PASS = 4'd7;
`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'd8;
`endif

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
`else
  typedef enum logic [1:0] {IDLE, DONE} state_e;
`endif

  state_e state_q, state_d;
  state_e accept_state;
  logic   accept;

  logic [WIDTH:0]   sum_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_illegal;
  logic             load_single;

  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             illegal_q, illegal_d;

`ifdef ALU_MUL_EN
  localparam logic [WIDTH-1:0] STEPS = WIDTH'(WIDTH);

  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               start_mul;
  logic               mul_done;

  assign start_mul    = accept && (alu_ctrl == OP_MUL);
  assign mul_done     = (state_q == BUSY) && (cnt_q == STEPS);
  assign accept_state = (alu_ctrl == OP_MUL) ? BUSY : DONE;
`else
  assign accept_state = DONE;
`endif

  assign accept      = in_valid && in_ready;
  assign load_single = accept && (accept_state == DONE);

  // Single-cycle ALU datapath on the live operands; only sampled at accept.
  always_comb begin
    sum_w       = {1'b0, a} + {1'b0, b};
    diff_w      = {1'b0, a} - {1'b0, b};
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        alu_res   = sum_w[WIDTH-1:0];
        alu_carry = sum_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = diff_w[WIDTH-1:0];
        alu_carry = diff_w[WIDTH];
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_SHL: begin
        alu_res   = {a[WIDTH-2:0], 1'b0};
        alu_carry = a[WIDTH-1];
      end
      OP_SHR: begin
        alu_res   = {1'b0, a[WIDTH-1:1]};
        alu_carry = a[0];
      end
      OP_PASS: alu_res = a;
      default: alu_illegal = 1'b1;
    endcase
  end

  // State register; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: DONE can chain straight into a new op when consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) state_d = accept_state;
      end
`ifdef ALU_MUL_EN
      BUSY: begin
        if (cnt_q == STEPS) state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = accept ? accept_state : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state; in_ready is held low in reset.
  always_comb begin
    out_valid = (state_q == DONE);
    in_ready  = rst_n && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  end

  // Result registers load only when a new result is produced, else hold.
  always_comb begin
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    if (load_single) begin
      result_d  = alu_res;
      carry_d   = alu_carry;
      zero_d    = (alu_res == '0);
      illegal_d = alu_illegal;
    end
`ifdef ALU_MUL_EN
    else if (mul_done) begin
      result_d  = prod_q[WIDTH-1:0];
      carry_d   = |prod_q[2*WIDTH-1:WIDTH];
      zero_d    = (prod_q[WIDTH-1:0] == '0);
      illegal_d = 1'b0;
    end
`endif
  end

  // Output result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef ALU_MUL_EN
  // Shift-add multiplier: one partial product per BUSY cycle, WIDTH steps,
  // then one more BUSY cycle in which the product is loaded into the outputs.
  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    if (start_mul) begin
      cnt_d    = '0;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      prod_d   = '0;
    end else if ((state_q == BUSY) && (cnt_q != STEPS)) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + WIDTH'(1);
    end
  end

  // Multiplier working registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end
`endif

  assign result    = result_q;
  assign carry_out = carry_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_pipe.md
# alu_pipe

Parametrised, handshaked successor to the 4-bit combinational ALU. Accepts one operation per transfer on a valid/ready input port, computes it in one cycle or as a multi-cycle shift-add multiply, and holds the registered result on a valid/ready output port until consumed. It sits between an operand-issuing controller and a result consumer, so either side can stall.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation offered
- in_ready  output  1  operation accepted on this edge if in_valid=1
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- alu_ctrl  input  4  opcode
- out_valid  output  1  result registers hold a valid result
- out_ready  input  1  consumer takes result on this edge if out_valid=1
- result  output  WIDTH  operation result
- carry_out  output  1  carry/borrow/shift-out/overflow flag
- zero  output  1  result == 0
- illegal  output  1  opcode was unsupported

One clock; reset is asynchronous and active-low.

## Operation
- Accept = in_valid && in_ready; a, b, alu_ctrl are captured at accept. Later input changes have no effect.
- Opcodes and carry_out:
  - 0 ADD: result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum
  - 1 SUB: result = (a-b) mod 2^WIDTH; carry = borrow (1 iff a<b unsigned)
  - 2 AND, 3 OR, 4 XOR: carry 0
  - 5 SHL by 1: carry = a[WIDTH-1]
  - 6 SHR by 1 (logical): carry = a[0]
  - 7 PASS A: carry 0
  - 8 MUL: see Configuration
  - 9..15: illegal
- Every legal op: illegal = 0 and zero = (result == 0).
- Illegal op: result 0, carry 0, zero 1, illegal 1. Latency is single-cycle.
- State machine:
  - IDLE: in_ready=1. Accepting a single-cycle op goes to DONE. Accepting MUL goes to BUSY.
  - BUSY: in_ready=0. Performs one shift-add step per cycle; a WIDTH-bit step counter goes to DONE after WIDTH steps.
  - DONE: out_valid=1. If out_ready=0, stay in DONE with outputs frozen. If out_ready=1 and no new accept, go to IDLE. If out_ready=1 and a new accept occurs, go to DONE or BUSY per the new op, so single-cycle ops sustain one per cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready); forced 0 while rst_n=0.

## Timing
- Reset values: out_valid 0, result 0, carry_out 0, zero 0, illegal 0, state IDLE, step counter 0.
- Reset asserted mid-MUL or in DONE: the operation is discarded immediately and asynchronously. No result is ever presented for it.
- Single-cycle op: accept on edge N gives out_valid=1 after edge N+1, i.e. the result is visible in the cycle after accept.
- MUL: accept on edge N gives out_valid=1 after edge N+WIDTH+1.
- result, carry_out, zero and illegal are registered and change only on the edge that loads a new result. They stay stable while out_valid && !out_ready.
- out_valid drops after the out_ready edge unless a new single-cycle op was accepted on that same edge.

## Configuration
- ALU_MUL_EN defined:
  - Opcode 8 is an unsigned multiply.
  - result = low WIDTH bits of the 2*WIDTH-bit product.
  - carry_out = OR of the high WIDTH product bits (overflow).
  - Latency WIDTH+1 via BUSY.
- ALU_MUL_EN undefined:
  - Opcode 8 is illegal; BUSY and the step counter are not built.
  - All ops are single-cycle.

## Test plan
Run with WIDTH=4.
- Reset: hold rst_n=0 -> out_valid=0, result=0, in_ready=0. After release -> in_ready=1.
- ADD a=9, b=8, op=0, out_ready=1 -> next cycle result=1, carry_out=1, zero=0, illegal=0. SUB a=3, b=5 -> result=14, carry_out=1. SUB a=5, b=5 -> result=0, zero=1, carry_out=0.
- Back-to-back: SHL a=9, then SHR a=9, then XOR a=5, b=5 on consecutive cycles with out_ready=1 -> three consecutive out_valid cycles: result=2/carry 1, result=4/carry 1, result=0/zero 1. in_ready stays 1 throughout.
- Backpressure: out_ready=0 after an AND a=12, b=10 -> result=8 held stable and in_ready=0 for 5 cycles. Raise out_ready -> exactly one transfer.
- MUL with ALU_MUL_EN: a=7, b=3 -> out_valid exactly 5 cycles after accept, result=5, carry_out=1. a=3, b=2 -> result=6, carry_out=0. Assert rst_n=0 during BUSY -> no out_valid follows.
- Illegal: op=12 (and op=8 without ALU_MUL_EN) -> result=0, zero=1, carry_out=0, illegal=1, one-cycle latency.
